// File: rtl/md_msg_decoder.sv
// Market-data message decoder: parses fixed 18-byte 'A' frames into symbol/price/quantity/side
// updates, drops malformed frames with a single error strobe, and keeps saturating counters.
module md_msg_decoder #(
   parameter logic [7:0] MSG_TYPE  = 8'h41,
   parameter logic [7:0] BUY_CODE  = 8'h42,
   parameter logic [7:0] SELL_CODE = 8'h53
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [63:0] symbol,
   output logic [31:0] price,
   output logic [31:0] quantity,
   output logic [7:0]  side,
   output logic        update_valid,
   output logic        frame_err,
   output logic [31:0] msg_count,
   output logic [31:0] err_count
);

   typedef enum logic [1:0] {StIdle, StBody, StEmit, StDrop} state_e;

   localparam logic [4:0] SideIdx = 5'd17;

   state_e       state_q;
   logic [4:0]   idx_q;
   // Body bytes 1..16 shift in MSB-first: [127:64] symbol, [63:32] price, [31:0] quantity.
   logic [127:0] body_q;

   logic accept;
   logic is_buy;
   logic is_sell;

   always_comb begin
      accept  = in_valid && in_ready;
      is_buy  = (in_data == BUY_CODE);
      is_sell = (in_data == SELL_CODE);
   end

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         idx_q        <= 5'd0;
         body_q       <= '0;
         in_ready     <= 1'b0;
         symbol       <= '0;
         price        <= '0;
         quantity     <= '0;
         side         <= '0;
         update_valid <= 1'b0;
         frame_err    <= 1'b0;
         msg_count    <= '0;
         err_count    <= '0;
      end else begin
         update_valid <= 1'b0;
         frame_err    <= 1'b0;
         in_ready     <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  if (in_data == MSG_TYPE && !in_last) begin
                     state_q <= StBody;
                     idx_q   <= 5'd1;
                  end else begin
                     frame_err <= 1'b1;
                     err_count <= sat_inc(err_count);
                     state_q   <= in_last ? StIdle : StDrop;
                     idx_q     <= 5'd0;
                  end
               end
            end
            StBody: begin
               if (accept) begin
                  if (idx_q != SideIdx) begin
                     if (in_last) begin
                        frame_err <= 1'b1;
                        err_count <= sat_inc(err_count);
                        state_q   <= StIdle;
                        idx_q     <= 5'd0;
                        body_q    <= '0;
                     end else begin
                        body_q <= {body_q[119:0], in_data};
                        idx_q  <= idx_q + 5'd1;
                     end
                  end else if ((is_buy || is_sell) && in_last) begin
                     // Outputs load on entry so they appear together with update_valid.
                     state_q      <= StEmit;
                     idx_q        <= 5'd0;
                     in_ready     <= 1'b0;
                     symbol       <= body_q[127:64];
                     price        <= body_q[63:32];
                     quantity     <= body_q[31:0];
                     side         <= is_buy ? 8'd0 : 8'd1;
                     update_valid <= 1'b1;
                     msg_count    <= sat_inc(msg_count);
                  end else begin
                     frame_err <= 1'b1;
                     err_count <= sat_inc(err_count);
                     state_q   <= in_last ? StIdle : StDrop;
                     idx_q     <= 5'd0;
                  end
               end
            end
            StEmit: begin
               state_q <= StIdle;
            end
            StDrop: begin
               if (accept && in_last) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   a_err_upd_excl : assert property (@(posedge clk) disable iff (!rstn)
      !(frame_err && update_valid));
   a_emit_not_ready : assert property (@(posedge clk) disable iff (!rstn)
      update_valid |-> !in_ready);
`endif

endmodule

// File: tb/tb_md_msg_decoder.sv
// Self-checking bench for md_msg_decoder: directed frame table, reset corner cases, and
// randomized frames checked against a frame-level reference model.
module tb_md_msg_decoder;

   localparam logic [7:0] MSG  = 8'h41;
   localparam logic [7:0] BUY  = 8'h42;
   localparam logic [7:0] SELL = 8'h53;

   typedef logic [7:0] byte_q_t[$];

   typedef struct {
      logic [7:0]  t;
      logic [63:0] s;
      logic [31:0] p;
      logic [31:0] q;
      logic [7:0]  sd;
      int unsigned len;
      int unsigned gap;
      bit          exp_good;
      logic [7:0]  exp_side;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [63:0] symbol;
   logic [31:0] price;
   logic [31:0] quantity;
   logic [7:0]  side;
   logic        update_valid;
   logic        frame_err;
   logic [31:0] msg_count;
   logic [31:0] err_count;

   md_msg_decoder dut (
      .clk          (clk),
      .rstn         (rstn),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .symbol       (symbol),
      .price        (price),
      .quantity     (quantity),
      .side         (side),
      .update_valid (update_valid),
      .frame_err    (frame_err),
      .msg_count    (msg_count),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge.
   int unsigned n_upd = 0, n_err = 0, n_both = 0, n_rdy_emit = 0, upd_cyc = 0;
   logic [63:0] cap_sym;
   logic [31:0] cap_p, cap_q;
   logic [7:0]  cap_side;
   always @(negedge clk) begin
      if (update_valid) begin
         n_upd    <= n_upd + 1;
         upd_cyc  <= cyc;
         cap_sym  <= symbol;
         cap_p    <= price;
         cap_q    <= quantity;
         cap_side <= side;
         if (in_ready) n_rdy_emit <= n_rdy_emit + 1;
      end
      if (frame_err) n_err <= n_err + 1;
      if (frame_err && update_valid) n_both <= n_both + 1;
   end

   int unsigned n_chk = 0, n_pass = 0;
   int unsigned last_acc = 0;

   // Reference model state: last emitted message and expected counters.
   logic [63:0] m_sym = '0;
   logic [31:0] m_p = '0, m_q = '0, m_msg = '0, m_err = '0;
   logic [7:0]  m_side = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic byte_q_t build(input logic [7:0] t, input logic [63:0] s,
                                     input logic [31:0] p, input logic [31:0] q,
                                     input logic [7:0] sd, input int unsigned len);
      byte_q_t b;
      b.push_back(t);
      for (int i = 7; i >= 0; i--) b.push_back(s[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) b.push_back(p[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) b.push_back(q[i*8 +: 8]);
      b.push_back(sd);
      while (b.size() > len) void'(b.pop_back());
      while (b.size() < len) b.push_back(8'($urandom));
      return b;
   endfunction

   // Frame-level rule: good only if exactly 18 bytes, right type, and a known side code.
   function automatic bit model_good(input byte_q_t b);
      if (b.size() != 18) return 1'b0;
      return (b[0] == MSG) && (b[17] == BUY || b[17] == SELL);
   endfunction

   function automatic logic [63:0] model_field(input byte_q_t b, input int first, input int n);
      logic [63:0] acc = '0;
      for (int i = 0; i < n; i++) acc = (acc << 8) | 64'(b[first + i]);
      return acc;
   endfunction

   task automatic send(input byte_q_t b, input bit do_last, input int unsigned gap_pct);
      int unsigned w;
      for (int i = 0; i < b.size(); i++) begin
         @(negedge clk);
         while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         w = 0;
         while (!in_ready && w < 20) begin
            in_valid = 1'b0;
            @(negedge clk);
            w++;
         end
         if (!in_ready) begin
            chk("ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
         end
         in_valid = 1'b1;
         in_data  = b[i];
         in_last  = do_last && (i == b.size() - 1);
         last_acc = cyc + 1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic run_frame(input string tag, input byte_q_t b, input int unsigned gap,
                            input bit exp_good, input logic [7:0] exp_side);
      int unsigned u0, e0;
      u0 = n_upd;
      e0 = n_err;
      send(b, 1'b1, gap);
      repeat (3) @(negedge clk);
      if (exp_good) begin
         m_sym  = model_field(b, 1, 8);
         m_p    = 32'(model_field(b, 9, 4));
         m_q    = 32'(model_field(b, 13, 4));
         m_side = exp_side;
         m_msg  = m_msg + 1;
      end else begin
         m_err = m_err + 1;
      end
      chk({tag, ".upd_pulses"}, 64'(n_upd - u0), exp_good ? 64'd1 : 64'd0);
      chk({tag, ".err_pulses"}, 64'(n_err - e0), exp_good ? 64'd0 : 64'd1);
      chk({tag, ".symbol"}, symbol, m_sym);
      chk({tag, ".price"}, 64'(price), 64'(m_p));
      chk({tag, ".quantity"}, 64'(quantity), 64'(m_q));
      chk({tag, ".side"}, 64'(side), 64'(m_side));
      chk({tag, ".msg_count"}, 64'(msg_count), 64'(m_msg));
      chk({tag, ".err_count"}, 64'(err_count), 64'(m_err));
      if (exp_good) begin
         chk({tag, ".latency"}, 64'(upd_cyc), 64'(last_acc));
         chk({tag, ".strobe_symbol"}, cap_sym, m_sym);
         chk({tag, ".strobe_side"}, 64'(cap_side), 64'(m_side));
      end
   endtask

   vec_t tbl[8];
   localparam logic [63:0] AAPL = 64'h4141504C00000000;
   localparam logic [63:0] MSFT = 64'h4D53465400000000;
   localparam logic [63:0] GOOG = 64'h474F4F4700000000;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t b;
      int unsigned e0, u0, r, len, gap;
      logic [7:0] t, sd;

      tbl[0] = '{MSG, AAPL, 32'd10000, 32'd100, BUY,   18, 0,  1'b1, 8'd0};
      tbl[1] = '{MSG, AAPL, 32'd10000, 32'd100, SELL,  18, 40, 1'b1, 8'd1};
      tbl[2] = '{MSG, AAPL, 32'd10000, 32'd100, BUY,   10, 0,  1'b0, 8'd0};
      tbl[3] = '{MSG, MSFT, 32'd4215,  32'd7,   SELL,  18, 0,  1'b1, 8'd1};
      tbl[4] = '{8'h58, AAPL, 32'd1,   32'd2,   BUY,   25, 20, 1'b0, 8'd0};
      tbl[5] = '{MSG, GOOG, 32'd55,    32'd66,  8'h00, 18, 0,  1'b0, 8'd0};
      tbl[6] = '{MSG, GOOG, 32'd55,    32'd66,  BUY,   19, 0,  1'b0, 8'd0};
      tbl[7] = '{MSG, GOOG, 32'hDEADBEEF, 32'h01020304, BUY, 18, 30, 1'b1, 8'd0};

      // Reset state.
      #1;
      chk("rst.in_ready", 64'(in_ready), 64'd0);
      chk("rst.update_valid", 64'(update_valid), 64'd0);
      chk("rst.frame_err", 64'(frame_err), 64'd0);
      chk("rst.symbol", symbol, 64'd0);
      chk("rst.msg_count", 64'(msg_count), 64'd0);
      chk("rst.err_count", 64'(err_count), 64'd0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst.ready_after_release", 64'(in_ready), 64'd1);

      for (int i = 0; i < 8; i++) begin
         b = build(tbl[i].t, tbl[i].s, tbl[i].p, tbl[i].q, tbl[i].sd, tbl[i].len);
         run_frame($sformatf("vec%0d", i), b, tbl[i].gap, tbl[i].exp_good, tbl[i].exp_side);
         if (i == 0) begin
            chk("vec0.abs_symbol", symbol, 64'h4141504C00000000);
            chk("vec0.abs_price", 64'(price), 64'd10000);
            chk("vec0.abs_quantity", 64'(quantity), 64'd100);
            chk("vec0.abs_msg_count", 64'(msg_count), 64'd1);
         end
      end

      // Reset in the middle of a frame: nothing is reported for the partial frame.
      e0 = n_err;
      u0 = n_upd;
      b = build(MSG, MSFT, 32'd9, 32'd9, BUY, 9);
      send(b, 1'b0, 0);
      rstn = 1'b0;
      #1;
      chk("midrst.msg_count", 64'(msg_count), 64'd0);
      chk("midrst.err_count", 64'(err_count), 64'd0);
      chk("midrst.symbol", symbol, 64'd0);
      chk("midrst.in_ready", 64'(in_ready), 64'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      m_sym = '0; m_p = '0; m_q = '0; m_side = '0; m_msg = '0; m_err = '0;
      @(negedge clk);
      chk("midrst.no_pulses", 64'(n_err - e0 + n_upd - u0), 64'd0);
      b = build(MSG, AAPL, 32'd777, 32'd888, SELL, 18);
      run_frame("midrst.frame", b, 0, 1'b1, 8'd1);

      // Randomized frames against the frame-level model.
      for (int k = 0; k < 40; k++) begin
         r   = $urandom_range(9);
         len = (r <= 5) ? 18 : (r == 6) ? 10 : (r == 7) ? 19 : (r == 8) ? 25 : 1;
         t   = ($urandom_range(9) == 0) ? 8'($urandom) : MSG;
         r   = $urandom_range(3);
         sd  = (r == 0) ? BUY : (r == 1) ? SELL : (r == 2) ? 8'h00 : 8'($urandom);
         gap = $urandom_range(50);
         b   = build(t, {$urandom, $urandom}, $urandom, $urandom, sd, len);
         run_frame($sformatf("rnd%0d", k), b, gap, model_good(b),
                   (b.size() == 18 && b[17] == SELL) ? 8'd1 : 8'd0);
      end

      chk("never_err_and_upd", 64'(n_both), 64'd0);
      chk("ready_low_in_emit", 64'(n_rdy_emit), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
